// File: rtl/crot_inv_gate_pipelined_pkg.sv
// Shared fixed-point constants and rotation-select encodings for the inverse-QFT gate chain.
package crot_inv_gate_pipelined_pkg;

  localparam int unsigned TOTAL_WIDTH  = 16;
  localparam int unsigned FRAC_WIDTH   = 14;
  localparam int unsigned INV_SQRT2_FX = 11585;

  typedef enum logic [1:0] {
    KSEL_ID  = 2'd0,
    KSEL_PI  = 2'd1,
    KSEL_PI2 = 2'd2,
    KSEL_PI4 = 2'd3
  } ksel_e;

  function automatic ksel_e eff_op(input logic ctrl, input logic [1:0] k_sel);
    return ctrl ? ksel_e'(k_sel) : KSEL_ID;
  endfunction

endpackage

// File: rtl/crot_inv_gate_pipelined_round_sat.sv
// Round-half-up arithmetic right shift by FRAC_W (optional) followed by saturation to DATA_W.
module fxp_round_sat #(
  parameter int unsigned IN_W   = 33,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC_W = 14
) (
  input  logic signed [IN_W-1:0]   i_val,
  input  logic                     i_shift_en,
  output logic signed [DATA_W-1:0] o_val
);

  localparam int unsigned EXT_W = IN_W + 1;
  localparam logic signed [EXT_W-1:0] RND  = EXT_W'(1) << (FRAC_W - 1);
  localparam logic signed [EXT_W-1:0] MAXV = {{(EXT_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] MINV = {{(EXT_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [EXT_W-1:0] w_ext;
  logic signed [EXT_W-1:0] w_rnd;
  logic signed [EXT_W-1:0] w_shr;
  logic signed [EXT_W-1:0] w_sel;

  // One guard bit keeps the rounding add from wrapping.
  assign w_ext = {i_val[IN_W-1], i_val};
  assign w_rnd = w_ext + RND;
  assign w_shr = w_rnd >>> FRAC_W;
  assign w_sel = i_shift_en ? w_shr : w_ext;

  always_comb begin
    o_val = w_sel[DATA_W-1:0];
    if (w_sel > MAXV)
      o_val = MAXV[DATA_W-1:0];
    else if (w_sel < MINV)
      o_val = MINV[DATA_W-1:0];
  end

endmodule

// File: rtl/crot_inv_gate_pipelined.sv
// Controlled inverse phase rotation exp(-j*theta), 3-stage pipeline with valid/ready backpressure.
module crot_inv_gate_pipelined
  import crot_inv_gate_pipelined_pkg::*;
#(
  parameter int unsigned DATA_W    = TOTAL_WIDTH,
  parameter int unsigned FRAC_W    = FRAC_WIDTH,
  parameter int unsigned INV_SQRT2 = INV_SQRT2_FX
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     ctrl,
  input  logic [1:0]               k_sel,
  input  logic signed [DATA_W-1:0] ar,
  input  logic signed [DATA_W-1:0] ai,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] pr,
  output logic signed [DATA_W-1:0] pi
);

  localparam int unsigned PROD_W = DATA_W + FRAC_W + 3;
  localparam logic signed [FRAC_W+1:0] W_K = (FRAC_W + 2)'(INV_SQRT2);

  logic w_en;

  logic                     r_s1_v;
  ksel_e                    r_s1_op;
  logic signed [DATA_W-1:0] r_s1_ar;
  logic signed [DATA_W-1:0] r_s1_ai;

  logic                     r_s2_v;
  ksel_e                    r_s2_op;
  logic signed [DATA_W:0]   r_s2_re;
  logic signed [DATA_W:0]   r_s2_im;

  logic                     r_s3_v;
  logic signed [DATA_W-1:0] r_s3_re;
  logic signed [DATA_W-1:0] r_s3_im;

  logic signed [DATA_W:0]   w_ar;
  logic signed [DATA_W:0]   w_ai;
  logic signed [DATA_W:0]   w_s2_re;
  logic signed [DATA_W:0]   w_s2_im;
  logic                     w_is_pi4;
  logic signed [PROD_W-1:0] w_prod_re;
  logic signed [PROD_W-1:0] w_prod_im;
  logic signed [PROD_W-1:0] w_rs_in_re;
  logic signed [PROD_W-1:0] w_rs_in_im;
  logic signed [DATA_W-1:0] w_s3_re;
  logic signed [DATA_W-1:0] w_s3_im;

  assign w_en      = !r_s3_v || out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_s3_v;
  assign pr        = r_s3_re;
  assign pi        = r_s3_im;

  // Stage 1: capture operands and the effective rotation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v  <= 1'b0;
      r_s1_op <= KSEL_ID;
      r_s1_ar <= '0;
      r_s1_ai <= '0;
    end else if (w_en) begin
      r_s1_v  <= in_valid;
      r_s1_op <= eff_op(ctrl, k_sel);
      r_s1_ar <= ar;
      r_s1_ai <= ai;
    end
  end

  // Stage 2 works one bit wider so negation of the most-negative value and the pi/4 sums are exact.
  assign w_ar = {r_s1_ar[DATA_W-1], r_s1_ar};
  assign w_ai = {r_s1_ai[DATA_W-1], r_s1_ai};

  always_comb begin
    w_s2_re = w_ar;
    w_s2_im = w_ai;
    case (r_s1_op)
      KSEL_PI: begin
        w_s2_re = -w_ar;
        w_s2_im = -w_ai;
      end
      KSEL_PI2: begin
        w_s2_re = w_ai;
        w_s2_im = -w_ar;
      end
      KSEL_PI4: begin
        w_s2_re = w_ar + w_ai;
        w_s2_im = w_ai - w_ar;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_v  <= 1'b0;
      r_s2_op <= KSEL_ID;
      r_s2_re <= '0;
      r_s2_im <= '0;
    end else if (w_en) begin
      r_s2_v  <= r_s1_v;
      r_s2_op <= r_s1_op;
      r_s2_re <= w_s2_re;
      r_s2_im <= w_s2_im;
    end
  end

  // Stage 3: pi/4 scales by 1/sqrt(2) and rounds; other ops use the same saturator with the shift bypassed.
  assign w_is_pi4   = (r_s2_op == KSEL_PI4);
  assign w_prod_re  = r_s2_re * W_K;
  assign w_prod_im  = r_s2_im * W_K;
  assign w_rs_in_re = w_is_pi4 ? w_prod_re : {{(PROD_W-DATA_W-1){r_s2_re[DATA_W]}}, r_s2_re};
  assign w_rs_in_im = w_is_pi4 ? w_prod_im : {{(PROD_W-DATA_W-1){r_s2_im[DATA_W]}}, r_s2_im};

  fxp_round_sat #(
    .IN_W   (PROD_W),
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_rs_re (
    .i_val      (w_rs_in_re),
    .i_shift_en (w_is_pi4),
    .o_val      (w_s3_re)
  );

  fxp_round_sat #(
    .IN_W   (PROD_W),
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_rs_im (
    .i_val      (w_rs_in_im),
    .i_shift_en (w_is_pi4),
    .o_val      (w_s3_im)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s3_v  <= 1'b0;
      r_s3_re <= '0;
      r_s3_im <= '0;
    end else if (w_en) begin
      r_s3_v  <= r_s2_v;
      r_s3_re <= w_s3_re;
      r_s3_im <= w_s3_im;
    end
  end

endmodule

// File: tb/tb_crot_inv_gate_pipelined.sv
// Self-checking bench: behavioural rotation model, per-cycle stream checker, directed and random traffic.
module tb_crot_inv_gate_pipelined;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic               ctrl = 1'b0;
  logic [1:0]         k_sel = 2'd0;
  logic signed [15:0] ar = '0;
  logic signed [15:0] ai = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [15:0] pr;
  logic signed [15:0] pi;

  crot_inv_gate_pipelined #(
    .DATA_W    (16),
    .FRAC_W    (14),
    .INV_SQRT2 (11585)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ctrl      (ctrl),
    .k_sel     (k_sel),
    .ar        (ar),
    .ai        (ai),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pr        (pr),
    .pi        (pi)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int errors = 0;
  int checks = 0;

  function automatic void check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic longint sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // exp(-j*theta) applied to (ar + j*ai); 1/sqrt(2) as 11585/2^14, rounded half up.
  function automatic void model(input bit c, input bit [1:0] k, input longint a, input longint b,
                                output longint opr, output longint opi);
    int op;
    op = c ? int'(k) : 0;
    case (op)
      0: begin opr = a; opi = b; end
      1: begin opr = sat16(-a); opi = sat16(-b); end
      2: begin opr = sat16(b); opi = sat16(-a); end
      default: begin
        opr = sat16(((a + b) * 11585 + 8192) >>> 14);
        opi = sat16(((b - a) * 11585 + 8192) >>> 14);
      end
    endcase
  endfunction

  typedef struct {
    longint epr;
    longint epi;
    longint tag;
  } exp_t;

  exp_t   q[$];
  longint ecnt = 0;
  int     outs = 0;
  longint cur_pr = 0;
  longint cur_pi = 0;
  bit     prev_stall = 0;
  longint prev_pr = 0;
  longint prev_pi = 0;

  // Stream checker: in_ready rule, hold-under-stall, ordering and exact 3-enabled-cycle latency.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      check("in_ready_rule", in_ready, (!out_valid || out_ready));
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_pr", pr, prev_pr);
        check("hold_pi", pi, prev_pi);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("pr", pr, e.epr);
          check("pi", pi, e.epi);
          check("latency", ecnt, e.tag + 3);
          outs++;
        end
      end else if (!out_valid && q.size() > 0 && q[0].tag + 3 <= ecnt) begin
        void'(q.pop_front());
        check("missing_output", 0, 1);
      end
      if (in_valid && in_ready) begin
        exp_t n;
        n.epr = cur_pr;
        n.epi = cur_pi;
        n.tag = ecnt;
        q.push_back(n);
      end
      if (!out_valid || out_ready) ecnt++;
      prev_stall = out_valid && !out_ready;
      prev_pr = pr;
      prev_pi = pi;
    end
  end

  task automatic send(input bit c, input bit [1:0] k, input longint a, input longint b,
                      input longint epr, input longint epi);
    bit acc;
    int n;
    in_valid = 1'b1;
    ctrl = c;
    k_sel = k;
    ar = 16'(a);
    ai = 16'(b);
    cur_pr = epr;
    cur_pi = epi;
    acc = 0;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) check("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic send_model(input bit c, input bit [1:0] k, input longint a, input longint b);
    longint mp, mi;
    model(c, k, a, b, mp, mi);
    send(c, k, a, b, mp, mi);
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(nm, q.size(), 0);
  endtask

  function automatic longint rand_amp();
    int sel;
    sel = $urandom_range(0, 7);
    case (sel)
      0: return -32768;
      1: return 32767;
      2: return $urandom_range(0, 3) - 2;
      default: return longint'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction

  typedef struct {
    bit     c;
    bit [1:0] k;
    longint a;
    longint b;
    longint epr;
    longint epi;
  } vec_t;

  vec_t dir[8];

  initial begin
    int base;
    int seen;
    longint mp, mi;

    dir[0] = '{1, 2'd2,   1000,  -2000,  -2000, -1000};
    dir[1] = '{0, 2'd2,   1000,  -2000,   1000, -2000};
    dir[2] = '{1, 2'd3,  16384,      0,  11585, -11585};
    dir[3] = '{1, 2'd3,  32767,  32767,  32767,     0};
    dir[4] = '{1, 2'd1, -32768,      5,  32767,    -5};
    dir[5] = '{1, 2'd2, -32768,      0,      0, 32767};
    dir[6] = '{1, 2'd0,      7,     -9,      7,    -9};
    dir[7] = '{1, 2'd1,    100,   -100,   -100,   100};

    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_pr", pr, 0);
    check("reset_pi", pi, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Directed: pin the model to hand-computed values, then check the DUT against the literals.
    foreach (dir[i]) begin
      model(dir[i].c, dir[i].k, dir[i].a, dir[i].b, mp, mi);
      check("model_pr", mp, dir[i].epr);
      check("model_pi", mi, dir[i].epi);
    end
    foreach (dir[i]) send(dir[i].c, dir[i].k, dir[i].a, dir[i].b, dir[i].epr, dir[i].epi);
    drain("directed_drain");

    // Backpressure: 5 back-to-back beats, stall 4 cycles once the first result is presented.
    base = outs;
    fork
      begin
        for (int i = 0; i < 5; i++)
          send_model(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), rand_amp(), rand_amp());
      end
      begin
        int n;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!out_valid && n < 100);
        check("bp_first_valid", out_valid, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check("bp_in_ready_low", in_ready, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain("bp_drain");
    check("bp_count", outs - base, 5);

    // Full-throughput random stream.
    base = outs;
    for (int i = 0; i < 100; i++)
      send_model(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), rand_amp(), rand_amp());
    drain("rand_drain");
    check("rand_count", outs - base, 100);

    // Reset with beats in flight: outputs clear immediately and nothing emerges afterwards.
    for (int i = 0; i < 3; i++)
      send_model(1'b1, 2'd3, rand_amp(), rand_amp());
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_pr", pr, 0);
    check("midrst_pi", pi, 0);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("midrst_no_output", seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
